microwave_timer: RTL
====================

# microwave_timer

Countdown controller for the microwave front panel. It consumes the 50 %-duty slow tick square wave produced by the panel clock divider, using one tick period as one second. It accepts a four-digit MM:SS keypad entry, counts it down while heating, and handles pause, resume and cancel. At zero it beeps for a fixed number of ticks. Outputs feed the seven-segment display driver and the magnetron/buzzer drivers.

## Interface
- BEEP_TICKS, 3, number of tick periods `beep` stays high after countdown reaches 0000 (≥1)
- clock_in  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- tick_in  input  1  slow square wave from divider; not synchronous to clock_in
- key_valid  input  1  one-cycle pulse: key_digit holds a new keypad digit
- key_digit  input  4  digit value; 0–9 accepted, 10–15 ignored
- start  input  1  one-cycle pulse: start/resume
- stop  input  1  one-cycle pulse: pause
- clear  input  1  one-cycle pulse: cancel and zero display
- door_open  input  1  level, high while door open
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display digits, registered
- heating  output  1  magnetron enable, registered, high only in RUN
- beep  output  1  buzzer enable, registered, high only in DONE
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset state: all digits 0, state IDLE, heating 0, beep 0, beep counter 0, tick synchronizer cleared.
- Tick handling:
  - tick_in passes through a 2-flop synchronizer (s1, s2) and a delay flop (prev).
  - tick_pulse = s2 & ~prev, one clock_in cycle per tick rising edge.
- Command priority when events share a cycle: clear > (stop | door_open) > start > key_valid > tick_pulse. A lower-priority event in that cycle is dropped, not deferred.
- IDLE:
  - key_valid with digit ≤ 9 shifts entry left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit. A fifth digit drops the old min_tens.
  - start with door closed and digits ≠ 0000 → RUN. start with 0000 or door open is ignored.
- RUN, on each tick_pulse, decrement by one second:
  - sec_ones > 0: sec_ones−1.
  - else sec_tens > 0: sec_tens−1, sec_ones=9.
  - else (seconds 00, minutes > 0): minutes decrement as a 2-digit BCD value, seconds load 59.
  - Seconds entries 60–99 are counted literally. 0099 takes 99 ticks; 0130 takes 90 ticks.
  - A decrement yielding 0000 → DONE on the same edge.
  - stop or door_open → PAUSE, digits held. key_valid is ignored.
- PAUSE:
  - tick_pulse and key_valid are ignored.
  - start with door closed → RUN. start with door open is ignored.
- DONE:
  - beep counter cleared on entry and incremented on each tick_pulse.
  - The tick_pulse that brings the count to BEEP_TICKS → IDLE.
  - key_valid, start, stop, clear or door_open → IDLE immediately (beep off). The keypress itself is not entered.
- clear in any state → IDLE with all digits 0.
- heating = (next_state == RUN) and beep = (next_state == DONE), both registered, so they change on the same edge as state.

## Timing
- tick_in rising edge sampled at clock_in edge N lands in s1. tick_pulse is high during cycle N+1 to N+2. Decrement is visible after edge N+2, i.e. the third sampling edge.
- Command pulses act on the edge where they are sampled high. State, digits, heating and beep all update at that edge (1-cycle latency).
- Reset is asynchronous assert. Mid-countdown reset forces outputs to reset values immediately; no tick is counted until reset_n is high and a new tick_in edge occurs.
- tick_in held high, or a held key_valid, generates no repeat action. Only rising edges and pulses count.

## Test plan
- Reset, key digits 1,3,0 then start; apply 90 tick edges -> digits 01:30→01:29…00:00, heating high 90 ticks, then DONE with beep for 3 ticks, then IDLE.
- Enter 0100, start, 1 tick -> 00:59. Enter 0005, start, 5 ticks -> 0000/DONE on 5th tick pulse edge, heating falls the same edge.
- RUN at 00:10, assert door_open with a tick_pulse in the same cycle -> PAUSE at 00:10, no decrement. Further ticks ignored. Door closed + start -> RUN, next tick -> 00:09.
- Start with 0000 -> stays IDLE, heating 0. Key digit 12 -> ignored. Five keys 1,2,3,4,5 -> 23:45.
- clear during RUN at 00:07 -> IDLE, 0000, heating 0 next edge. Key press during DONE -> IDLE, beep 0, digits 0000.
- Drop reset_n mid-RUN between clock edges -> all outputs 0/IDLE at once. Release, verify tick edge-detect latency of exactly 3 edges after restart.

Source files
------------

// File: rtl/microwave_timer.sv
// microwave_timer: MM:SS keypad-entry countdown controller for the microwave
// front panel. One rising edge of the slow tick square wave counts as one
// second. Handles start/pause/resume/cancel and a fixed-length end-of-cook beep.
//
// Ports:
//   clock_in        system clock, rising edge
//   reset_n         asynchronous active-low reset
//   tick_in         slow tick square wave, asynchronous to clock_in
//   key_valid       1-cycle pulse qualifying key_digit (0-9 accepted)
//   key_digit[3:0]  keypad digit
//   start/stop/clear 1-cycle command pulses
//   door_open       level, high while the door is open
//   min_tens, min_ones, sec_tens, sec_ones [3:0]  registered BCD display digits
//   heating         registered magnetron enable (RUN only)
//   beep            registered buzzer enable (DONE only)
//   state[1:0]      IDLE=0, RUN=1, PAUSE=2, DONE=3
module microwave_timer #(
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       heating,
    output logic       beep,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = (BEEP_TICKS < 2) ? 1 : $clog2(BEEP_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_next_state;
    logic [3:0]         r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [3:0]         w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;
    logic [3:0]         w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic               w_dec_zero;
    logic [CNT_W-1:0]   r_beep_cnt, w_beep_cnt_nxt;
    logic               r_heating, r_beep;
    logic               r_s1, r_s2, r_prev;
    logic               w_tick_pulse;
    logic               w_hold;
    logic               w_entry_nz;

    // Tick synchronizer and rising-edge detect
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= tick_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_tick_pulse = r_s2 & ~r_prev;
    assign w_hold       = stop | door_open;
    assign w_entry_nz   = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} != 16'h0000);

    // One-second decrement; seconds above 59 are counted down literally
    always_comb begin
        w_dec_mt = r_min_tens;
        w_dec_mo = r_min_ones;
        w_dec_st = r_sec_tens;
        w_dec_so = r_sec_ones;
        if (r_sec_ones != 4'd0) begin
            w_dec_so = r_sec_ones - 4'd1;
        end else if (r_sec_tens != 4'd0) begin
            w_dec_st = r_sec_tens - 4'd1;
            w_dec_so = 4'd9;
        end else if ({r_min_tens, r_min_ones} != 8'h00) begin
            if (r_min_ones != 4'd0) begin
                w_dec_mo = r_min_ones - 4'd1;
            end else begin
                w_dec_mt = r_min_tens - 4'd1;
                w_dec_mo = 4'd9;
            end
            w_dec_st = 4'd5;
            w_dec_so = 4'd9;
        end
        w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'h0000);
    end

    // Next-state and next-data; the highest-priority event present owns the cycle
    always_comb begin
        w_next_state   = r_state;
        w_nxt_mt       = r_min_tens;
        w_nxt_mo       = r_min_ones;
        w_nxt_st       = r_sec_tens;
        w_nxt_so       = r_sec_ones;
        w_beep_cnt_nxt = r_beep_cnt;
        if (clear) begin
            w_next_state = S_IDLE;
            w_nxt_mt     = 4'd0;
            w_nxt_mo     = 4'd0;
            w_nxt_st     = 4'd0;
            w_nxt_so     = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hold) begin
                        w_next_state = S_IDLE;
                    end else if (start) begin
                        if (w_entry_nz) w_next_state = S_RUN;
                    end else if (key_valid && (key_digit <= 4'd9)) begin
                        w_nxt_mt = r_min_ones;
                        w_nxt_mo = r_sec_tens;
                        w_nxt_st = r_sec_ones;
                        w_nxt_so = key_digit;
                    end
                end
                S_RUN: begin
                    if (w_hold) begin
                        w_next_state = S_PAUSE;
                    end else if (start || key_valid) begin
                        w_next_state = S_RUN;
                    end else if (w_tick_pulse) begin
                        w_nxt_mt = w_dec_mt;
                        w_nxt_mo = w_dec_mo;
                        w_nxt_st = w_dec_st;
                        w_nxt_so = w_dec_so;
                        if (w_dec_zero) begin
                            w_next_state   = S_DONE;
                            w_beep_cnt_nxt = CNT_W'(0);
                        end
                    end
                end
                S_PAUSE: begin
                    if (!w_hold && start) w_next_state = S_RUN;
                end
                S_DONE: begin
                    if (w_hold || start || key_valid) begin
                        w_next_state = S_IDLE;
                    end else if (w_tick_pulse) begin
                        w_beep_cnt_nxt = r_beep_cnt + CNT_W'(1);
                        if ((r_beep_cnt + CNT_W'(1)) == CNT_W'(BEEP_TICKS))
                            w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State, digit and output registers
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_beep_cnt <= CNT_W'(0);
            r_heating  <= 1'b0;
            r_beep     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_min_tens <= w_nxt_mt;
            r_min_ones <= w_nxt_mo;
            r_sec_tens <= w_nxt_st;
            r_sec_ones <= w_nxt_so;
            r_beep_cnt <= w_beep_cnt_nxt;
            r_heating  <= (w_next_state == S_RUN);
            r_beep     <= (w_next_state == S_DONE);
        end
    end

    assign min_tens = r_min_tens;
    assign min_ones = r_min_ones;
    assign sec_tens = r_sec_tens;
    assign sec_ones = r_sec_ones;
    assign heating  = r_heating;
    assign beep     = r_beep;
    assign state    = r_state;

endmodule
